// File: rtl/apb_slave_responder.sv
// APB4 completer: a bank of 32-bit registers behind a run-time programmable
// wait-state counter, flagging misaligned/out-of-range accesses with pslverr.
module apb_slave_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NO_OF_REGS = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [3:0]              wait_cycles,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDXW   = (NO_OF_REGS > 1) ? $clog2(NO_OF_REGS) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    err, err_nxt;
  logic [IDXW-1:0]         idx, idx_nxt;
  logic [ADDR_WIDTH-3:0]   word;
  logic                    addr_err;
  logic                    setup;
  logic                    wr_en;
  logic [NO_OF_REGS-1:0][NBYTES-1:0][7:0] regs;

  assign word     = paddr[ADDR_WIDTH-1:2];
  assign addr_err = (paddr[1:0] != 2'b00) || (word >= (ADDR_WIDTH-2)'(NO_OF_REGS));
  assign setup    = psel && !penable;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
      idx   <= idx_nxt;
    end
  end

  // A setup phase seen in ACCESS restarts the transfer rather than being dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = ACCESS;
          cnt_nxt   = wait_cycles;
          err_nxt   = addr_err;
          idx_nxt   = word[IDXW-1:0];
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (!penable) begin
          cnt_nxt = wait_cycles;
          err_nxt = addr_err;
          idx_nxt = word[IDXW-1:0];
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  assign pready  = (state == ACCESS) && psel && penable && (cnt == 4'd0);
  assign pslverr = pready && err;
  assign wr_en   = pready && pwrite && !err;
  assign prdata  = (pready && !pwrite && !err) ? regs[idx] : '0;

  for (genvar r = 0; r < NO_OF_REGS; r++) begin : g_reg
    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
      always_ff @(posedge pclk or posedge preset) begin
        if (preset)
          regs[r][b] <= '0;
        else if (wr_en && (idx == IDXW'(r)) && pstrb[b])
          regs[r][b] <= pwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/apb_slave_responder.md
Name: apb_slave_responder

Overview:
- Synthesizable APB4 completer, the responder end of the APB link driven by the master agent.
- Holds a bank of NO_OF_REGS 32-bit registers.
- Inserts a run-time programmable number of wait states.
- Flags misaligned or out-of-range addresses with pslverr.
- Instantiated once per slave (NO_OF_SLAVES) as the DUT for the AVIP environment, so master-agent sequences run against real RTL.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; must be 32.
- NO_OF_REGS, 16, number of word registers; legal word index 0..NO_OF_REGS-1.

Ports:
- pclk  input  1  APB clock; all state changes on rising edge.
- preset  input  1  asynchronous, active-high reset.
- psel  input  1  slave select.
- penable  input  1  access-phase strobe.
- pwrite  input  1  1=write, 0=read.
- paddr  input  ADDR_WIDTH  byte address.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  write byte strobes.
- wait_cycles  input  4  wait states inserted per transfer; sampled in setup phase.
- prdata  output  DATA_WIDTH  read data.
- pready  output  1  transfer complete.
- pslverr  output  1  transfer error; valid only with pready.

Behaviour:
- Clock and reset: one clock, pclk. Reset is asynchronous and active-high on preset.
- Reset state:
  - While preset=1: state=IDLE, wait counter=0, all registers=0.
  - Outputs: pready=0, pslverr=0, prdata=0.
  - Reset asserted mid-transfer aborts the transfer; no write is committed.
- FSM states: IDLE, ACCESS.
- IDLE:
  - psel=1 and penable=0 (setup phase) -> ACCESS.
  - On that transition: latch cnt<=wait_cycles, latch err flag, latch word index.
  - psel=1 with penable=1 in IDLE is a protocol violation: ignored, stay IDLE, pready=0.
- ACCESS, with psel=1 and penable=1:
  - cnt!=0: cnt decrements each cycle, pready=0.
  - cnt==0: pready=1 (combinational from state and cnt).
  - The clock edge with pready=1 completes the transfer and returns to IDLE.
- ACCESS, with psel=0 (aborted): return to IDLE next edge, no write, pready stays 0.
- ACCESS, with psel=1 and penable=0 (illegal re-setup): treated as a new setup; relatch cnt, err and index; stay ACCESS.
- Latency:
  - Completion occurs in access-phase cycle wait_cycles+1.
  - wait_cycles=0 gives zero-wait APB: 2 cycles per transfer.
  - wait_cycles=15 gives 17 cycles per transfer.
- Back-to-back transfers: psel held high with penable low in the cycle after completion is accepted as the next setup, with no idle cycle.
- Address decode:
  - index = paddr[ADDR_WIDTH-1:2].
  - err=1 if paddr[1:0]!=0 or index>=NO_OF_REGS.
- Write:
  - Committed on the completing edge only if pwrite=1 and err=0.
  - Byte lane k is updated from pwdata[8k+7:8k] only if pstrb[k]=1.
  - pstrb=0 completes normally with no change.
- Read:
  - While pready=1 and pwrite=0: prdata = reg[index] if err=0, else 0.
  - prdata=0 whenever pready=0 or on writes.
- pslverr: equals err while pready=1, otherwise 0. An erroring write modifies no register.
- Read after write: a read of the same register in the next transfer returns the new value (no forwarding hazard).
- Handshake constraint: pwrite, paddr, pwdata and pstrb are stable during ACCESS per APB. RTL uses the live values at the completing edge; the latched index is used for decode.

Test Plan:
- Reset/idle: assert preset mid-write with wait_cycles=3 -> pready=0, prdata=0, pslverr=0 immediately; subsequent read of addr 0x0 returns 0x00000000.
- Zero-wait write/read: wait_cycles=0; write 0xDEADBEEF to 0x8, pstrb=0xF; then read 0x8 -> pready high in first access cycle each time, prdata=0xDEADBEEF, pslverr=0, 2 cycles per transfer.
- Wait states: wait_cycles=5; read 0x4 -> pready low for 5 access cycles, high on the 6th, single-cycle pulse.
- Byte strobes: reg 0xC=0x11223344; write 0xAABBCCDD with pstrb=0x5 -> read returns 0x11BB33DD.
- Errors:
  - Write 0x40 (index 16) -> pslverr=1 with pready, no register changes.
  - Read 0x2 (misaligned) -> pslverr=1, prdata=0.
- Back-to-back and abort:
  - Three consecutive writes without idle cycles all commit.
  - psel dropped during wait state (wait_cycles=4, third access cycle) -> no write, next transfer completes normally.
